clk_reset_gen: RTL and testbench
================================

# clk_reset_gen

Parametrised clock-enable and reset sequencer between the PLL and the system core. It takes the fast PLL clock and the PLL lock flag and produces NUM_DIV power-of-two divided square waves and matching single-cycle enables. It also produces a stretched, active-high system reset. The reset re-asserts automatically on loss of PLL lock, and a sticky flag records each lock loss.

## Interface
Parameters:
- NUM_DIV, default 2: number of divided outputs; output i divides clk by 2^(i+1). Legal range 1..8.
- RESET_CYCLES, default 15: number of clk cycles the STRETCH state lasts. Must be ≥ 1.
- LOCK_SYNC, default 2: number of synchroniser flops on pll_locked. Must be ≥ 2.

Ports:
- clk, in, 1: PLL output clock. The only clock in the block.
- reset_n, in, 1: synchronous, active-low reset. Overrides all other inputs.
- pll_locked, in, 1: PLL lock indication, asynchronous to clk.
- ce, out, NUM_DIV: ce[i] is a one-clk pulse once every 2^(i+1) cycles while in RUN.
- clk_div, out, NUM_DIV: clk_div[i] is a 50% square wave of period 2^(i+1) cycles while in RUN.
- sys_reset, out, 1: active-high reset to the core; high whenever the FSM is not in RUN.
- lock_lost, out, 1: sticky; set when lock drops while in RUN; cleared only by reset_n.

## Operation
- **Lock synchroniser:** pll_locked passes through a LOCK_SYNC-flop chain to produce locked_s. Only locked_s is used internally.
- **FSM:** one-hot, three states. sys_reset is the inverted RUN flop, so it is a direct register output with no decode.
  - **WAIT_LOCK:** moves to STRETCH when locked_s = 1, with stretch_cnt cleared to 0.
  - **STRETCH:**
    - If locked_s = 0, go to WAIT_LOCK.
    - Else if stretch_cnt = RESET_CYCLES-1, go to RUN.
    - Otherwise increment stretch_cnt.
    - stretch_cnt is clog2(RESET_CYCLES)+1 bits wide and never wraps.
  - **RUN:**
    - If locked_s = 0, go to WAIT_LOCK and set lock_lost.
    - Otherwise div_cnt increments.
- **div_cnt:** NUM_DIV bits. It increments only in RUN and wraps modulo 2^NUM_DIV. Leaving RUN (by lock loss or reset_n) clears it to 0.
- **Divided outputs:**
  - clk_div[i] = div_cnt[i], a registered bit.
  - ce[i] = RUN & (div_cnt[i:0] all ones). It is combinational from flops and asserts in the last cycle of each clk_div[i] period.
- **Reset values (reset_n = 0 at a clk edge):**
  - State WAIT_LOCK; synchroniser flops, stretch_cnt and div_cnt all 0.
  - Outputs: sys_reset = 1, ce = 0, clk_div = 0, lock_lost = 0.
  - This applies from any state, including mid-STRETCH and mid-RUN.
- **Priority:** reset_n first, then lock loss, then counting.
- A lock drop in STRETCH does not set lock_lost.

## Timing
- **Lock-to-release latency:** pll_locked goes high before edge 1 and stays high.
  - locked_s is high after edge LOCK_SYNC; STRETCH is entered at edge LOCK_SYNC+1.
  - RUN is entered, and sys_reset falls, after edge LOCK_SYNC+1+RESET_CYCLES. With defaults this is edge 18.
- **Phase after release:** call the first cycle with sys_reset = 0 RUN cycle 1; div_cnt = 0 in that cycle.
  - ce[i] first pulses in RUN cycle 2^(i+1), then every 2^(i+1) cycles.
  - clk_div[i] first rises in RUN cycle 2^i + 1.
- **Lock-loss latency:** pll_locked falls before edge 1.
  - sys_reset rises and lock_lost sets after edge LOCK_SYNC+1.
  - ce and clk_div are 0 from that same cycle.
- A lock glitch shorter than one clk cycle may or may not be captured. If captured, it is handled as a full lock loss.
- **Re-lock after loss:** the full stretch sequence is repeated, and phase restarts exactly as after power-on.

## Test plan
- **Power-on:** reset_n low for 3 cycles, then high; pll_locked high from the start. Required: sys_reset = 1 through edge 18 and 0 after it. In RUN, ce[0] pulses on RUN cycles 2, 4, 6… and ce[1] on RUN cycles 4, 8, 12…. clk_div[1] shows period 4 (the 4 MHz equivalent at 16 MHz clk).
- **No lock:** pll_locked held 0 for 100 cycles. Required: sys_reset stays 1, ce = 0, clk_div = 0, lock_lost = 0 throughout.
- **Lock loss in RUN:** after release, pll_locked drops for 5 cycles and then returns. Required: sys_reset rises 3 edges after the drop and lock_lost = 1 from then on. After re-lock, sys_reset falls 18 edges after pll_locked returns, and the first ce[0] lands in RUN cycle 2. lock_lost stays 1.
- **Lock drop mid-STRETCH:** pll_locked drops at the 8th edge, then recovers 2 cycles later. Required: the stretch restarts from 0, lock_lost stays 0, and the release is 18 edges after recovery.
- **reset_n mid-RUN, coinciding with a lock drop:** reset_n is pulsed low for one cycle in RUN, in the same cycle as the lock drop. Required: sys_reset = 1, div_cnt = 0 and lock_lost = 0 next cycle, because reset_n wins.
- **Parameter sweep:** NUM_DIV = 4, RESET_CYCLES = 1, LOCK_SYNC = 3. Required: release after edge 5; ce[3] every 16 cycles, first in RUN cycle 16; clk_div[3] high for 8 cycles and low for 8.

Source files
------------

// File: rtl/clk_reset_gen.sv
// clk_reset_gen: lock-synchronised, stretched system reset plus power-of-two clock dividers and enables
module clk_reset_gen #(
  parameter int NUM_DIV      = 2,
  parameter int RESET_CYCLES = 15,
  parameter int LOCK_SYNC    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  output logic [NUM_DIV-1:0] ce,
  output logic [NUM_DIV-1:0] clk_div,
  output logic               sys_reset,
  output logic               lock_lost
);
  localparam int SW = $clog2(RESET_CYCLES) + 1;
  typedef enum logic [2:0] {WAIT_LOCK = 3'b001, STRETCH = 3'b010, RUN = 3'b100} state_t;
  state_t               r_state;
  logic [LOCK_SYNC-1:0] r_sync;
  logic [SW-1:0]        r_stretch;
  logic [NUM_DIV-1:0]   r_div;
  logic                 r_lock_lost;
  logic                 w_locked_s;
  logic                 w_run;
  assign w_locked_s = r_sync[LOCK_SYNC-1];
  // one-hot encoding: the RUN bit is itself the release flop
  assign w_run      = r_state[2];
  assign sys_reset  = ~w_run;
  assign clk_div    = r_div;
  assign lock_lost  = r_lock_lost;
  for (genvar i = 0; i < NUM_DIV; i++) begin : g_ce
    assign ce[i] = w_run & (&r_div[i:0]);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= WAIT_LOCK;
      r_sync      <= '0;
      r_stretch   <= '0;
      r_div       <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_sync <= {r_sync[LOCK_SYNC-2:0], pll_locked};
      unique case (r_state)
        WAIT_LOCK: if (w_locked_s) begin
          r_state   <= STRETCH;
          r_stretch <= '0;
        end
        STRETCH: begin
          if (!w_locked_s) r_state <= WAIT_LOCK;
          else if (r_stretch == SW'(RESET_CYCLES - 1)) r_state <= RUN;
          else r_stretch <= r_stretch + SW'(1);
        end
        RUN: begin
          if (!w_locked_s) begin
            r_state     <= WAIT_LOCK;
            r_lock_lost <= 1'b1;
            r_div       <= '0;
          end else r_div <= r_div + NUM_DIV'(1);
        end
        default: r_state <= WAIT_LOCK;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_reset_gen.sv
// tb_clk_reset_gen: directed checks of release timing, divider phase and lock-loss handling
module tb_clk_reset_gen;
  logic       clk = 1'b0;
  logic       reset_n, pll_locked, reset_b_n, pll_locked_b;
  logic [1:0] ce, clk_div;
  logic       sys_reset, lock_lost;
  logic [3:0] ce_b, clk_div_b;
  logic       sys_reset_b, lock_lost_b;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  clk_reset_gen dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .ce(ce), .clk_div(clk_div), .sys_reset(sys_reset), .lock_lost(lock_lost)
  );
  clk_reset_gen #(.NUM_DIV(4), .RESET_CYCLES(1), .LOCK_SYNC(3)) dut_b (
    .clk(clk), .reset_n(reset_b_n), .pll_locked(pll_locked_b),
    .ce(ce_b), .clk_div(clk_div_b), .sys_reset(sys_reset_b), .lock_lost(lock_lost_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0; pll_locked = 1'b1; reset_b_n = 1'b0; pll_locked_b = 1'b0;
    repeat (3) step();
    chk("reset_state", {sys_reset, ce, clk_div, lock_lost}, 6'b100000);
    reset_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step();
      chk("por_sys_reset", sys_reset, e < 18);
    end
    for (int k = 1; k <= 16; k++) begin
      chk("por_ce0", ce[0], k % 2 == 0);
      chk("por_ce1", ce[1], k % 4 == 0);
      chk("por_div1", clk_div[1], (k - 1) % 4 >= 2);
      if (k < 16) step();
    end
    pll_locked = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("loss_sys_reset", sys_reset, e >= 3);
      chk("loss_lock_lost", lock_lost, e >= 3);
      if (e >= 3) chk("loss_outputs", {ce, clk_div}, 4'b0000);
    end
    pll_locked = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step();
      chk("relock_sys_reset", sys_reset, e < 18);
      chk("relock_sticky", lock_lost, 1);
    end
    chk("relock_c1", {ce, clk_div}, 4'b0000);
    step();
    chk("relock_c2_ce0", ce[0], 1);
    step();
    step();
    chk("relock_c4", {ce, clk_div}, 4'b1111);
    reset_n = 1'b0; pll_locked = 1'b0;
    step();
    chk("rst_wins", {sys_reset, ce, clk_div, lock_lost}, 6'b100000);
    reset_n = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      step();
      chk("no_lock", {sys_reset, ce, clk_div, lock_lost}, 6'b100000);
    end
    reset_n = 1'b0; pll_locked = 1'b1;
    step();
    reset_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      if (e == 8) pll_locked = 1'b0;
      if (e == 10) pll_locked = 1'b1;
      step();
      chk("stretch_drop_sys_reset", sys_reset, e < 27);
      chk("stretch_drop_lock_lost", lock_lost, 0);
    end
    pll_locked_b = 1'b1;
    step();
    chk("b_reset_state", {sys_reset_b, ce_b, clk_div_b, lock_lost_b}, 10'b1000000000);
    reset_b_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("b_sys_reset", sys_reset_b, e < 5);
    end
    for (int k = 1; k <= 32; k++) begin
      chk("b_ce3", ce_b[3], k % 16 == 0);
      chk("b_ce0", ce_b[0], k % 2 == 0);
      chk("b_div3", clk_div_b[3], (k - 1) % 16 >= 8);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
